// File: rtl/trigger_capture.sv
// trigger_capture
//   Receiving end of the theremin trigger interface. Re-arms the trigger
//   generator with a clr_o burst, waits for a trig_i pulse, measures its high
//   time in clk cycles and offers the result to the consumer with valid/ack.
//
//   Handshake: valid_o rises when a result is latched and stays high, with
//   count_o/overflow_o frozen, until ack_i is seen high on a clock edge;
//   ack_i is ignored while valid_o is low. count_o/overflow_o keep the last
//   result after the ack until a new one is latched.
//
//   Optional feature: define TRIGGER_CAPTURE_AVG_EN to average four
//   back-to-back measurements per capture (count_o = sum >> 2).
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous reset, active-low
//   arm        in   start one capture (sampled only in IDLE)
//   trig_i     in   asynchronous trigger pulse
//   clr_o      out  clear to trigger generator, high during CLEAR
//   count_o    out  measured high time in clk cycles
//   overflow_o out  counter saturated during the capture
//   valid_o    out  result available, held until ack_i
//   ack_i      in   consumer accepts result
//   busy_o     out  high in every state except IDLE
//   state_dbg  out  current FSM state, for checkers

module trigger_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CLR_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             trig_i,
    output logic             clr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             valid_o,
    input  logic             ack_i,
    output logic             busy_o,
    output logic [2:0]       state_dbg
);

    localparam int CLR_W = $clog2(CLR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLD      = 3'd4
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ts, tp, rise, fall;
    logic [CLR_W-1:0]       clr_cnt;
    logic [CNT_W-1:0]       cnt;
    logic                   ovf;
    logic                   last_meas;

    // Synchronizer plus one extra flop for edge detection. tp tracks ts in
    // every state, so a trigger already high on entering WAIT_RISE produces
    // no rise and the FSM waits for the next rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            tp     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trig_i};
            tp     <= ts;
        end
    end

    assign ts   = sync_q[SYNC_STAGES-1];
    assign rise = ts & ~tp;
    assign fall = ~ts & tp;

`ifdef TRIGGER_CAPTURE_AVG_EN
    logic [CNT_W+1:0] acc;
    logic [CNT_W+1:0] acc_sum;
    logic [1:0]       idx;
    logic             ovf_any;

    assign acc_sum   = acc + {2'b00, cnt};
    assign last_meas = (idx == 2'd3);
`else
    assign last_meas = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_n = state;
        clr_o   = 1'b0;
        valid_o = 1'b0;
        busy_o  = 1'b1;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (arm) state_n = CLEAR;
            end
            CLEAR: begin
                clr_o = 1'b1;
                if (clr_cnt == CLR_W'(1)) state_n = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) state_n = MEASURE;
            end
            MEASURE: begin
                if (fall) state_n = last_meas ? HOLD : CLEAR;
            end
            HOLD: begin
                valid_o = 1'b1;
                if (ack_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: clear-burst counter, width counter and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt    <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            count_o    <= '0;
            overflow_o <= 1'b0;
`ifdef TRIGGER_CAPTURE_AVG_EN
            acc        <= '0;
            idx        <= '0;
            ovf_any    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        clr_cnt <= CLR_W'(CLR_CYCLES);
`ifdef TRIGGER_CAPTURE_AVG_EN
                        acc     <= '0;
                        idx     <= '0;
                        ovf_any <= 1'b0;
`endif
                    end
                end
                CLEAR: clr_cnt <= clr_cnt - CLR_W'(1);
                WAIT_RISE: begin
                    // The rise cycle itself is the first high cycle.
                    if (rise) begin
                        cnt <= CNT_W'(1);
                        ovf <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (ts) begin
                        if (cnt == CNT_MAX) ovf <= 1'b1;
                        else                cnt <= cnt + CNT_W'(1);
                    end else if (fall) begin
`ifdef TRIGGER_CAPTURE_AVG_EN
                        if (last_meas) begin
                            count_o    <= acc_sum[CNT_W+1:2];
                            overflow_o <= ovf_any | ovf;
                        end else begin
                            acc     <= acc_sum;
                            idx     <= idx + 2'd1;
                            ovf_any <= ovf_any | ovf;
                            clr_cnt <= CLR_W'(CLR_CYCLES);
                        end
`else
                        count_o    <= cnt;
                        overflow_o <= ovf;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = state;

endmodule
